// File: rtl/clock_overlay_pkg.sv
// Shared types and constants for the clock overlay renderer.
// FSM states, glyph codes, default geometry, BCD helper.
package clock_overlay_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_BLANK = 4'd11;

  localparam int DEF_DATASIZE    = 24;
  localparam int DEF_ADDRSIZE    = 20;
  localparam int DEF_CR_ADDRSIZE = 9;
  localparam int DEF_GLYPH_W     = 13;
  localparam int DEF_GLYPH_H     = 24;
  localparam int DEF_LINE_STRIDE = 256;
  localparam int DEF_ORIGIN      = 59544;

  // {tens, ones} of a value below 64
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 6'd10);
    o = 4'(v % 6'd10);
    return {t, o};
  endfunction

endpackage

// File: rtl/time_counter_bcd.sv
// Time-of-day counter with load/tick and glyph-code outputs.
// Ports: clk, reset, Init_time, time_load, tick, hour12 -> ht..so.
module time_counter_bcd
  import clock_overlay_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] Init_time,
  input  logic        time_load,
  input  logic        tick,
  input  logic        hour12,
  output logic [3:0]  ht,
  output logic [3:0]  ho,
  output logic [3:0]  mt,
  output logic [3:0]  mo,
  output logic [3:0]  st,
  output logic [3:0]  so
);

  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic [4:0] hd;
  logic [7:0] hb;
  logic [7:0] mb;
  logic [7:0] sb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hh <= '0;
      mm <= '0;
      ss <= '0;
    end else if (time_load) begin
      hh <= (Init_time[23:16] > 8'd23) ? 5'd0 : Init_time[20:16];
      mm <= (Init_time[15:8] > 8'd59) ? 6'd0 : Init_time[13:8];
      ss <= (Init_time[7:0] > 8'd59) ? 6'd0 : Init_time[5:0];
    end else if (tick) begin
      if (ss == 6'd59) begin
        ss <= '0;
        if (mm == 6'd59) begin
          mm <= '0;
          hh <= (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        end else begin
          mm <= mm + 6'd1;
        end
      end else begin
        ss <= ss + 6'd1;
      end
    end
  end

  always_comb begin
    hd = hh;
    if (hour12) begin
      if (hh == 5'd0)
        hd = 5'd12;
      else if (hh > 5'd12)
        hd = hh - 5'd12;
    end
    hb = to_bcd({1'b0, hd});
    mb = to_bcd(mm);
    sb = to_bcd(ss);
  end

  // leading zero of the hour is blanked in 12-hour mode
  assign ht = (hour12 && hb[7:4] == 4'd0) ? GLYPH_BLANK : hb[7:4];
  assign ho = hb[3:0];
  assign mt = mb[7:4];
  assign mo = mb[3:0];
  assign st = sb[7:4];
  assign so = sb[3:0];

endmodule

// File: rtl/clock_overlay_render.sv
// Renders HH:MM[:SS] glyphs from the glyph ROM into image memory.
// Ports: time inputs, render handshake, ROM (CR_*), image memory (IM_*).
module clock_overlay_render
  import clock_overlay_pkg::*;
#(
  parameter int DATASIZE    = DEF_DATASIZE,
  parameter int ADDRSIZE    = DEF_ADDRSIZE,
  parameter int CR_ADDRSIZE = DEF_CR_ADDRSIZE,
  parameter int GLYPH_W     = DEF_GLYPH_W,
  parameter int GLYPH_H     = DEF_GLYPH_H,
  parameter int LINE_STRIDE = DEF_LINE_STRIDE,
  parameter int ORIGIN      = DEF_ORIGIN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [23:0]            Init_time,
  input  logic                   time_load,
  input  logic                   tick,
  input  logic                   render_req,
  input  logic [ADDRSIZE-1:0]    FB_Addr,
  input  logic                   hour12,
  input  logic                   show_sec,
  input  logic                   transparent,
  input  logic [DATASIZE-1:0]    fg_color,
  input  logic [DATASIZE-1:0]    bg_color,
  input  logic [GLYPH_W-1:0]     CR_Q,
  output logic [CR_ADDRSIZE-1:0] CR_A,
  output logic [ADDRSIZE-1:0]    IM_A,
  output logic [DATASIZE-1:0]    IM_D,
  output logic                   IM_WEN,
  output logic                   busy,
  output logic                   done
);

  localparam int RW = $clog2(GLYPH_H);
  localparam int XW = $clog2(GLYPH_W);
  localparam logic [RW-1:0] R_LAST = RW'(GLYPH_H - 1);
  localparam logic [XW-1:0] X_LAST = XW'(GLYPH_W - 1);

  state_t state;
  state_t state_n;
  logic accept;
  logic busy_n;
  logic done_n;

  logic [3:0] ht, ho, mt, mo, st, so;
  logic [3:0] live [8];
  logic [3:0] code_q [8];
  logic [2:0] c, c_last, nc;
  logic [RW-1:0] r, nr;
  logic [XW-1:0] x;
  logic [GLYPH_W-1:0] row_bits;
  logic trans_q, pend;
  logic row_end, glyph_end, last;
  logic [DATASIZE-1:0] fg_q, bg_q;
  logic [ADDRSIZE-1:0] row_base;

  time_counter_bcd u_time (
    .clk       (clk),
    .reset     (reset),
    .Init_time (Init_time),
    .time_load (time_load),
    .tick      (tick),
    .hour12    (hour12),
    .ht        (ht),
    .ho        (ho),
    .mt        (mt),
    .mo        (mo),
    .st        (st),
    .so        (so)
  );

  assign live[0] = ht;
  assign live[1] = ho;
  assign live[2] = GLYPH_COLON;
  assign live[3] = mt;
  assign live[4] = mo;
  assign live[5] = GLYPH_COLON;
  assign live[6] = st;
  assign live[7] = so;

  function automatic logic [CR_ADDRSIZE-1:0] rom_addr(
    input logic [3:0]    code,
    input logic [RW-1:0] row
  );
    return CR_ADDRSIZE'(int'(code) * GLYPH_H + int'(row));
  endfunction

  assign row_end   = (x == X_LAST);
  assign glyph_end = (r == R_LAST);
  assign last      = glyph_end && (c == c_last);
  assign nr        = glyph_end ? '0 : r + RW'(1);
  assign nc        = glyph_end ? c + 3'd1 : c;
  assign row_base  = ADDRSIZE'(ORIGIN) + FB_Addr
                   + ADDRSIZE'(int'(r) * LINE_STRIDE)
                   + ADDRSIZE'(int'(c) * GLYPH_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (render_req) begin
          state_n = FETCH;
          accept  = 1'b1;
        end
      end
      FETCH: state_n = WAIT;
      WAIT:  state_n = WRITE;
      WRITE: begin
        if (row_end)
          state_n = last ? DONE : FETCH;
      end
      DONE: begin
        if (pend || render_req) begin
          state_n = FETCH;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy_n = (state_n == FETCH) || (state_n == WAIT) ||
             (state_n == WRITE);
    done_n = (state_n == DONE);
  end

  // CR_A is set on entry to FETCH so CR_Q is valid during WAIT;
  // pixel outputs are set one cycle early so they line up with WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CR_A     <= '0;
      IM_A     <= '0;
      IM_D     <= '0;
      IM_WEN   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      c        <= '0;
      c_last   <= '0;
      r        <= '0;
      x        <= '0;
      row_bits <= '0;
      pend     <= 1'b0;
      trans_q  <= 1'b0;
      fg_q     <= '0;
      bg_q     <= '0;
      for (int i = 0; i < 8; i++)
        code_q[i] <= '0;
    end else begin
      busy   <= busy_n;
      done   <= done_n;
      IM_WEN <= 1'b1;
      if (accept) begin
        code_q  <= live;
        c_last  <= show_sec ? 3'd7 : 3'd4;
        trans_q <= transparent;
        fg_q    <= fg_color;
        bg_q    <= bg_color;
        c       <= '0;
        r       <= '0;
        pend    <= 1'b0;
        CR_A    <= rom_addr(live[0], '0);
      end else if (render_req && state != IDLE) begin
        pend <= 1'b1;
      end
      case (state)
        WAIT: begin
          row_bits <= CR_Q << 1;
          x        <= '0;
          IM_A     <= row_base;
          IM_D     <= CR_Q[GLYPH_W-1] ? fg_q : bg_q;
          IM_WEN   <= trans_q && !CR_Q[GLYPH_W-1];
        end
        WRITE: begin
          if (!row_end) begin
            x        <= x + XW'(1);
            row_bits <= row_bits << 1;
            IM_A     <= IM_A + ADDRSIZE'(1);
            IM_D     <= row_bits[GLYPH_W-1] ? fg_q : bg_q;
            IM_WEN   <= trans_q && !row_bits[GLYPH_W-1];
          end else begin
            r <= nr;
            c <= nc;
            if (!last)
              CR_A <= rom_addr(code_q[nc], nr);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_overlay_render.sv
// Self-checking bench for clock_overlay_render.
// Random ROM/time/config against a behavioural render model.
module tb_clock_overlay_render;

  logic        clk = 0;
  logic        reset;
  logic [23:0] Init_time;
  logic        time_load, tick, render_req;
  logic [19:0] FB_Addr;
  logic        hour12, show_sec, transparent;
  logic [23:0] fg_color, bg_color;
  logic [12:0] CR_Q;
  logic [8:0]  CR_A;
  logic [19:0] IM_A;
  logic [23:0] IM_D;
  logic        IM_WEN, busy, done;

  clock_overlay_render dut (
    .clk         (clk),
    .reset       (reset),
    .Init_time   (Init_time),
    .time_load   (time_load),
    .tick        (tick),
    .render_req  (render_req),
    .FB_Addr     (FB_Addr),
    .hour12      (hour12),
    .show_sec    (show_sec),
    .transparent (transparent),
    .fg_color    (fg_color),
    .bg_color    (bg_color),
    .CR_Q        (CR_Q),
    .CR_A        (CR_A),
    .IM_A        (IM_A),
    .IM_D        (IM_D),
    .IM_WEN      (IM_WEN),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [12:0] rom [512];
  always @(posedge clk) CR_Q <= rom[CR_A];

  int n_chk = 0;
  int n_fail = 0;
  int mh, mm, ms;
  int codes [8];
  int exp_busy, act_busy, act_done;
  logic [43:0] exp_w [$];
  logic [43:0] act_w [$];
  int exp_cr [$];
  int act_cr [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_tick();
    ms++;
    if (ms == 60) begin
      ms = 0;
      mm++;
      if (mm == 60) begin
        mm = 0;
        mh = (mh + 1) % 24;
      end
    end
  endfunction

  task automatic set_time(input int h, m, s, input bit with_tick);
    Init_time = {8'(h), 8'(m), 8'(s)};
    time_load = 1;
    tick = with_tick;
    @(negedge clk);
    time_load = 0;
    tick = 0;
    mh = (h > 23) ? 0 : h;
    mm = (m > 59) ? 0 : m;
    ms = (s > 59) ? 0 : s;
  endtask

  task automatic do_tick();
    tick = 1;
    @(negedge clk);
    tick = 0;
    model_tick();
  endtask

  task automatic build_exp();
    int hd, nch, addr, code;
    logic [12:0] w;
    bit b;
    hd = mh;
    if (hour12) hd = (mh == 0) ? 12 : (mh > 12 ? mh - 12 : mh);
    codes[0] = (hour12 && hd < 10) ? 11 : hd / 10;
    codes[1] = hd % 10;
    codes[2] = 10;
    codes[3] = mm / 10;
    codes[4] = mm % 10;
    codes[5] = 10;
    codes[6] = ms / 10;
    codes[7] = ms % 10;
    nch = show_sec ? 8 : 5;
    exp_busy = nch * 24 * 15;
    exp_w.delete();
    exp_cr.delete();
    for (int c = 0; c < nch; c++)
      for (int r = 0; r < 24; r++) begin
        code = codes[c] * 24 + r;
        exp_cr.push_back(code);
        w = rom[code];
        for (int x = 0; x < 13; x++) begin
          b = w[12 - x];
          addr = (59544 + int'(FB_Addr) + r * 256 + c * 13 + x) % (1 << 20);
          if (!transparent || b)
            exp_w.push_back({20'(addr), b ? fg_color : bg_color});
        end
      end
  endtask

  task automatic collect(input bit do_req, input bit pulses,
                         input bit tick_mid);
    bit seen;
    int last_cr;
    act_w.delete();
    act_cr.delete();
    act_busy = 0;
    act_done = 0;
    last_cr = -1;
    seen = 0;
    if (do_req) begin
      render_req = 1;
      @(negedge clk);
      render_req = 0;
    end
    for (int n = 0; n < 4000 && !seen; n++) begin
      if (busy) begin
        act_busy++;
        if (int'(CR_A) != last_cr) begin
          act_cr.push_back(int'(CR_A));
          last_cr = int'(CR_A);
        end
      end
      if (!IM_WEN) act_w.push_back({IM_A, IM_D});
      if (done) begin
        act_done++;
        seen = 1;
      end
      tick = tick_mid && (n == 100);
      render_req = pulses && (n == 50 || n == 60);
      if (tick) model_tick();
      @(negedge clk);
    end
    tick = 0;
    render_req = 0;
    chk("done_seen", seen, 1);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic compare(input string tag);
    int errs, n;
    chk({tag, "_busy"}, act_busy, exp_busy);
    chk({tag, "_nwr"}, act_w.size(), exp_w.size());
    errs = 0;
    n = (act_w.size() < exp_w.size()) ? act_w.size() : exp_w.size();
    for (int i = 0; i < n; i++)
      if (act_w[i] !== exp_w[i]) errs++;
    chk({tag, "_wr_errs"}, errs, 0);
    chk({tag, "_ncr"}, act_cr.size(), exp_cr.size());
    errs = 0;
    n = (act_cr.size() < exp_cr.size()) ? act_cr.size() : exp_cr.size();
    for (int i = 0; i < n; i++)
      if (act_cr[i] != exp_cr[i]) errs++;
    chk({tag, "_cr_errs"}, errs, 0);
    chk({tag, "_ndone"}, act_done, 1);
  endtask

  task automatic run_render(input string tag, input bit pulses,
                            input bit tick_mid);
    build_exp();
    collect(1, pulses, tick_mid);
    compare(tag);
  endtask

  task automatic cfg(input bit h12, ss, tr, input logic [19:0] fb);
    hour12 = h12;
    show_sec = ss;
    transparent = tr;
    FB_Addr = fb;
    fg_color = 24'($urandom);
    bg_color = 24'($urandom);
  endtask

  int cnt;

  initial begin
    reset = 0;
    Init_time = 0;
    time_load = 0;
    tick = 0;
    render_req = 0;
    FB_Addr = 0;
    hour12 = 0;
    show_sec = 1;
    transparent = 0;
    fg_color = 0;
    bg_color = 0;
    mh = 0;
    mm = 0;
    ms = 0;
    for (int i = 0; i < 512; i++) rom[i] = 13'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_wen", IM_WEN, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cra", CR_A, 0);
    chk("rst_ima", IM_A, 0);
    chk("rst_imd", IM_D, 0);
    reset = 1;
    @(negedge clk);

    // 12:34:59 + tick -> 12:35:00
    set_time(12, 34, 59, 0);
    do_tick();
    cfg(0, 1, 0, 20'd0);
    run_render("t1235", 0, 0);
    chk("t1235_cr0", act_cr.size() > 0 ? act_cr[0] : -1, 24);
    chk("t1235_cr1", act_cr.size() > 24 ? act_cr[24] : -1, 48);
    chk("t1235_nwr", act_w.size(), 2496);
    chk("t1235_first_a", act_w.size() > 0 ? act_w[0][43:24] : 20'hFFFFF,
        59544);
    chk("t1235_last_a", act_w.size() > 0 ? act_w[$][43:24] : 20'h0,
        65535);

    // rollover to midnight, 12-hour shows 12
    set_time(23, 59, 59, 0);
    do_tick();
    cfg(1, 0, 0, 20'($urandom));
    run_render("mid12", 0, 0);
    chk("mid12_cr0", act_cr.size() > 0 ? act_cr[0] : -1, 24);
    chk("mid12_cr1", act_cr.size() > 24 ? act_cr[24] : -1, 48);

    // invalid load clamps, load beats simultaneous tick
    set_time(24, 60, 60, 1);
    cfg(0, 1, 0, 20'd0);
    run_render("clamp", 0, 1);
    chk("clamp_cr0", act_cr.size() > 0 ? act_cr[0] : -1, 0);

    // 15h in 12-hour mode -> blank, 3
    set_time(15, $urandom_range(59), $urandom_range(59), 0);
    cfg(1, 1, 0, 20'($urandom));
    run_render("h15", 0, 0);
    chk("h15_cr0", act_cr.size() > 0 ? act_cr[0] : -1, 264);
    chk("h15_cr1", act_cr.size() > 24 ? act_cr[24] : -1, 72);

    // transparent with sparse rows; tick mid-render ignored
    for (int i = 0; i < 512; i++) rom[i] = 13'h1001;
    cfg(0, 1, 1, 20'($urandom));
    fg_color = 24'hFF0000;
    run_render("trans", 0, 1);
    chk("trans_nwr", act_w.size(), 8 * 24 * 2);
    chk("trans_d0", act_w.size() > 0 ? act_w[0][23:0] : 24'h0,
        24'hFF0000);

    // randomized renders
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 512; i++) rom[i] = 13'($urandom);
      set_time($urandom_range(25), $urandom_range(61),
               $urandom_range(61), 0);
      cfg(1'($urandom), 1'($urandom), 1'($urandom), 20'($urandom));
      run_render($sformatf("rnd%0d", k), 0, 1'($urandom));
    end

    // two requests while busy -> exactly one extra render
    cfg(0, 0, 0, 20'($urandom));
    run_render("pend1", 1, 0);
    chk("pend_busy_next", busy, 1);
    build_exp();
    collect(0, 0, 0);
    compare("pend2");
    cnt = 0;
    repeat (5) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    chk("pend_no_third", cnt, 0);

    // reset mid-render
    cfg(0, 1, 0, 20'd0);
    render_req = 1;
    @(negedge clk);
    render_req = 0;
    repeat (500) @(negedge clk);
    reset = 0;
    #1;
    chk("mrst_wen", IM_WEN, 1);
    chk("mrst_busy", busy, 0);
    mh = 0;
    mm = 0;
    ms = 0;
    @(negedge clk);
    reset = 1;
    cnt = 0;
    repeat (40) begin
      if (!IM_WEN || busy) cnt++;
      @(negedge clk);
    end
    chk("mrst_quiet", cnt, 0);
    run_render("after_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
